spike_frame_serializer: RTL and testbench

SPIKE_FRAME_SERIALIZER -- requirements
Module: spike_frame_serializer

---
 rtl/spike_frame_serializer.sv | 114 +++++++++++
 tb/tb_spike_frame_serializer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : spike_frame_serializer
//  Description : Parallel-to-serial spike word transmitter. A free-running
//                frame counter is broadcast to downstream SIPO registers;
//                one bit of the loaded word (LSB first) is presented on
//                serial_out and advanced each time the counter passes the
//                SIPO sampling slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_frame_serializer #(
   parameter int N          = 16,
   parameter int FRAME_LEN  = 17,
   parameter int SHIFT_SLOT = 15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         load_valid,
   input  logic [N-1:0] load_data,
   output logic         load_ready,
   output logic [4:0]   global_counter,
   output logic         serial_out,
   output logic         busy,
   output logic         done
);

   // Bit counter must hold the value N after the final sample without wrapping.
   localparam int          CW       = $clog2(N + 1);
   localparam logic [4:0]  LAST_CNT = 5'(FRAME_LEN - 1);
   localparam logic [4:0]  SLOT     = 5'(SHIFT_SLOT);
   localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [N-1:0]    word;
   logic [N-1:0]    word_nxt;
   logic [CW-1:0]   bit_cnt;
   logic [CW-1:0]   bit_cnt_nxt;
   logic            sample_edge;

   // Frame timebase: counts 0..FRAME_LEN-1 while enabled, holds otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         global_counter <= 5'd0;
      end else if (en) begin
         if (global_counter == LAST_CNT) begin
            global_counter <= 5'd0;
         end else begin
            global_counter <= global_counter + 5'd1;
         end
      end
   end

   // State, shift word and bit counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         word    <= '0;
         bit_cnt <= '0;
      end else begin
         state   <= state_nxt;
         word    <= word_nxt;
         bit_cnt <= bit_cnt_nxt;
      end
   end

   // Next-state and output decode. The sample edge uses the counter value
   // seen before the edge, so a load landing on the slot edge is not sampled
   // until the slot comes round again.
   always_comb begin
      state_nxt   = state;
      word_nxt    = word;
      bit_cnt_nxt = bit_cnt;
      load_ready  = (state == ST_IDLE);
      busy        = (state == ST_SHIFT);
      done        = (state == ST_DONE);
      serial_out  = (state == ST_SHIFT) ? word[0] : 1'b0;
      sample_edge = (state == ST_SHIFT) && en && (global_counter == SLOT);

      case (state)
         ST_IDLE: begin
            if (load_valid) begin
               word_nxt    = load_data;
               bit_cnt_nxt = '0;
               state_nxt   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (sample_edge) begin
               word_nxt    = {1'b0, word[N-1:1]};
               bit_cnt_nxt = bit_cnt + CW'(1);
               if (bit_cnt == LAST_BIT) begin
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_spike_frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spike_frame_serializer
//  Description : Self-checking bench for spike_frame_serializer with a
//                behavioural frame/word model and a reference SIPO.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_frame_serializer;

   localparam int N    = 16;
   localparam int FL   = 17;
   localparam int SLOT = 15;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic         load_valid = 1'b0;
   logic [N-1:0] load_data = '0;
   logic         load_ready;
   logic [4:0]   global_counter;
   logic         serial_out;
   logic         busy;
   logic         done;

   spike_frame_serializer #(.N(N), .FRAME_LEN(FL), .SHIFT_SLOT(SLOT)) dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .load_valid     (load_valid),
      .load_data      (load_data),
      .load_ready     (load_ready),
      .global_counter (global_counter),
      .serial_out     (serial_out),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   int done_cnt = 0;
   bit checking = 1'b0;

   // Behavioural model: frame position, transfer phase (0 idle, 1 sending,
   // 2 finished), the word being sent and how many of its bits were sampled.
   int           m_cnt = 0;
   int           m_phase = 0;
   int           m_k = 0;
   logic [N-1:0] m_data = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_cnt   <= 0;
         m_phase <= 0;
         m_k     <= 0;
         m_data  <= '0;
      end else begin
         if (en) m_cnt <= (m_cnt + 1) % FL;
         case (m_phase)
            0: if (load_valid) begin
                  m_data  <= load_data;
                  m_k     <= 0;
                  m_phase <= 1;
               end
            1: if (en && m_cnt == SLOT) begin
                  m_k <= m_k + 1;
                  if (m_k + 1 == N) m_phase <= 2;
               end
            default: m_phase <= 0;
         endcase
      end
   end

   // Reference downstream SIPO: samples serial_out when the broadcast counter
   // hits the slot; first-sent bit ends up in the LSB after N samples.
   logic [N-1:0] sipo = '0;
   always @(posedge clk) begin
      if (rst) sipo <= '0;
      else if (en && global_counter == 5'(SLOT)) sipo <= {serial_out, sipo[N-1:1]};
   end

   // Per-cycle comparison of all outputs against the model.
   always @(posedge clk) begin
      #1;
      if (checking) begin
         logic       e_ser;
         logic [4:0] e_cnt;
         e_cnt = 5'(m_cnt);
         e_ser = (m_phase == 1) ? m_data[m_k] : 1'b0;
         n_total++;
         if (global_counter === e_cnt && serial_out === e_ser &&
             load_ready === (m_phase == 0) && busy === (m_phase == 1) &&
             done === (m_phase == 2))
            n_pass++;
         else
            $display("FAIL cycle_compare t=%0t got cnt=%0d ser=%b rdy=%b busy=%b done=%b expected cnt=%0d ser=%b rdy=%b busy=%b done=%b",
                     $time, global_counter, serial_out, load_ready, busy, done,
                     e_cnt, e_ser, (m_phase == 0), (m_phase == 1), (m_phase == 2));
         if (done === 1'b1) done_cnt++;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; load_valid = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_cnt(input int v);
      for (int i = 0; i < 64 && global_counter != 5'(v); i++) tick();
      chk("align_counter", 32'(global_counter), 32'(v));
   endtask

   task automatic load_word(input logic [N-1:0] d);
      load_valid = 1'b1; load_data = d;
      tick();
      load_valid = 1'b0;
   endtask

   // Counts edges after the load edge until done is observed high.
   task automatic wait_done(input int budget, output int n);
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk("done_seen", 32'(done), 32'd1);
   endtask

   task automatic wait_samples(input int k);
      int s = 0;
      for (int i = 0; i < 2000 && s < k; i++) begin
         if (busy && en && global_counter == 5'(SLOT)) s++;
         tick();
      end
      chk("sample_edges_reached", 32'(s), 32'(k));
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int d0;
      logic [4:0] c_hold;
      logic       s_hold;

      // Reset values
      do_reset();
      checking = 1'b1;
      chk("reset_counter", 32'(global_counter), 32'd0);
      chk("reset_ready",   32'(load_ready), 32'd1);
      chk("reset_busy",    32'(busy), 32'd0);
      chk("reset_done",    32'(done), 32'd0);
      chk("reset_serial",  32'(serial_out), 32'd0);

      // Counter wrap and hold
      en = 1'b1;
      repeat (17) tick();
      chk("wrap_to_zero", 32'(global_counter), 32'd0);
      repeat (22) tick();
      chk("wrap_39_edges", 32'(global_counter), 32'd5);
      en = 1'b0;
      repeat (3) tick();
      chk("hold_en_low", 32'(global_counter), 32'd5);

      // Word transfer loaded at counter 3: first sample 12 edges later,
      // last sample 15 frames after that.
      do_reset(); en = 1'b1;
      wait_cnt(3);
      d0 = done_cnt;
      load_word(16'hA5C3);
      wait_done(400, n);
      chk("xfer_latency", 32'(n), 32'(12 + 15 * FL));
      chk("xfer_sipo", 32'(sipo), 32'hA5C3);
      tick();
      chk("xfer_ready_after", 32'(load_ready), 32'd1);
      chk("xfer_done_once", 32'(done_cnt - d0), 32'd1);

      // Load on the slot edge: first sample a full frame later.
      do_reset(); en = 1'b1;
      wait_cnt(SLOT);
      load_word(16'h0001);
      chk("boundary_serial", 32'(serial_out), 32'd1);
      wait_done(400, n);
      chk("boundary_latency", 32'(n), 32'(FL + 15 * FL));
      chk("boundary_sipo", 32'(sipo), 32'h0001);

      // Backpressure: new word offered throughout the transfer.
      do_reset(); en = 1'b1;
      load_valid = 1'b1; load_data = 16'h1234;
      tick();
      load_data = 16'hFFFF;
      wait_done(400, n);
      chk("bp_sipo", 32'(sipo), 32'h1234);
      chk("bp_ready_in_done", 32'(load_ready), 32'd0);
      tick();
      chk("bp_ready_idle", 32'(load_ready), 32'd1);
      tick();
      chk("bp_accepted_busy", 32'(busy), 32'd1);
      chk("bp_accepted_bit0", 32'(serial_out), 32'd1);
      load_valid = 1'b0;

      // Stall mid-transfer.
      do_reset(); en = 1'b1;
      load_word(16'h8001);
      wait_samples(8);
      en = 1'b0;
      c_hold = global_counter;
      s_hold = serial_out;
      repeat (5) begin
         tick();
         chk("stall_counter", 32'(global_counter), 32'(c_hold));
         chk("stall_serial", 32'(serial_out), 32'(s_hold));
      end
      en = 1'b1;
      wait_done(400, n);
      chk("stall_sipo", 32'(sipo), 32'h8001);

      // Reset in the middle of a transfer.
      do_reset(); en = 1'b1;
      load_word(16'h3C5A);
      wait_samples(7);
      d0 = done_cnt;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_counter", 32'(global_counter), 32'd0);
      chk("midrst_serial",  32'(serial_out), 32'd0);
      chk("midrst_busy",    32'(busy), 32'd0);
      chk("midrst_done",    32'(done), 32'd0);
      chk("midrst_ready",   32'(load_ready), 32'd1);
      load_word(16'h0F0F);
      chk("midrst_reload", 32'(busy), 32'd1);
      chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 15000; i++) begin
         rst        = ($urandom_range(0, 2999) == 0);
         en         = ($urandom_range(0, 7) != 0);
         load_valid = ($urandom_range(0, 3) == 0);
         load_data  = N'($urandom);
         tick();
      end
      rst = 1'b0; load_valid = 1'b0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
